// File: rtl/input_conditioner_if.sv
// input_conditioner_if: pin-conditioner bus; master drives raw_in/debounce_en/clear_events, slave returns clean_out/rise_pulse/fall_pulse/event_sticky
interface input_conditioner_if #(parameter int N_INPUTS = 4);
  logic [N_INPUTS-1:0] raw_in, debounce_en, clear_events;
  logic [N_INPUTS-1:0] clean_out, rise_pulse, fall_pulse, event_sticky;
  modport master (
    output raw_in, debounce_en, clear_events,
    input  clean_out, rise_pulse, fall_pulse, event_sticky
  );
  modport slave (
    input  raw_in, debounce_en, clear_events,
    output clean_out, rise_pulse, fall_pulse, event_sticky
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel 2-flop sync + debounce/bypass, edge strobes and sticky event flags; ports clk, rst (async high), bus (slave)
module input_conditioner #(
  parameter int N_INPUTS = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  input_conditioner_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_INPUTS-1:0] s1_q, s2_q, en_q, clean_q, clean_d, rise_q, fall_q, sticky_q, sticky_d;
  logic [N_INPUTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  // counter defaults to 0: covers agreement, bypass and mode-change edges alike
  always_comb begin
    clean_d = clean_q;
    cnt_d = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (!bus.debounce_en[i]) clean_d[i] = s2_q[i];
      else if (bus.debounce_en[i] == en_q[i] && s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == LAST) clean_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    sticky_d = (clean_d ^ clean_q) | (sticky_q & ~bus.clear_events);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      en_q <= '0;
      cnt_q <= '0;
      clean_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      sticky_q <= '0;
    end else begin
      s1_q <= bus.raw_in;
      s2_q <= s1_q;
      en_q <= bus.debounce_en;
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      rise_q <= clean_d & ~clean_q;
      fall_q <= ~clean_d & clean_q;
      sticky_q <= sticky_d;
    end
  end
  assign bus.clean_out = clean_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.event_sticky = sticky_q;
endmodule
